// File: rtl/parallel_cpu_mult_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | parallel_cpu_mult_pkg                                              |
// | Shared op encoding, slice-count helpers and high-word correction.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package parallel_cpu_mult_pkg;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULXSS = 2'd1,
      MULXSU = 2'd2,
      MULXUU = 2'd3
   } mult_op_t;

   // Widest operand the correction helper handles; callers zero-extend into it.
   localparam int unsigned MAX_DATA_W = 128;

   typedef logic [MAX_DATA_W-1:0] wide_t;

   function automatic int unsigned num_slices(input int unsigned data_w, input int unsigned pp_w);
      return data_w / pp_w;
   endfunction

   function automatic int unsigned num_pp(input int unsigned data_w, input int unsigned pp_w);
      return (data_w / pp_w) * (data_w / pp_w);
   endfunction

   // Converts the unsigned high word into the signed/mixed high word.
   // Only the low DATA_W bits of the return value are meaningful.
   function automatic wide_t sign_correct(input wide_t    h,
                                          input wide_t    a,
                                          input wide_t    b,
                                          input logic     a_neg,
                                          input logic     b_neg,
                                          input mult_op_t op);
      wide_t corr;
      corr = '0;
      if ((op == MULXSS || op == MULXSU) && a_neg) begin
         corr = corr + b;
      end
      if (op == MULXSS && b_neg) begin
         corr = corr + a;
      end
      return h - corr;
   endfunction

endpackage
`default_nettype wire

// File: rtl/parallel_cpu_mult_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | parallel_cpu_mult_pipe_if                                          |
// | Operation request and result handshake bundle for the multiplier.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface parallel_cpu_mult_pipe_if #(
   parameter int unsigned DATA_W = 32
);
   import parallel_cpu_mult_pkg::*;

   logic              in_valid;
   logic              in_ready;
   mult_op_t          op;
   logic [DATA_W-1:0] src1;
   logic [DATA_W-1:0] src2;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] result;

   modport master (
      output in_valid, op, src1, src2, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, op, src1, src2, out_ready,
      output in_ready, out_valid, result
   );

endinterface
`default_nettype wire

// File: rtl/parallel_cpu_mult_pp_slice.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | parallel_cpu_mult_pp_slice                                         |
// | Registered unsigned PP_W x PP_W product (one hard multiplier).     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module parallel_cpu_mult_pp_slice #(
   parameter int unsigned PP_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_en,
   input  logic [PP_W-1:0]   i_a,
   input  logic [PP_W-1:0]   i_b,
   output logic [2*PP_W-1:0] o_prod
);

   logic [2*PP_W-1:0] r_prod;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prod <= '0;
      end else if (i_en) begin
         r_prod <= (2*PP_W)'(i_a) * (2*PP_W)'(i_b);
      end
   end

   assign o_prod = r_prod;

endmodule
`default_nettype wire

// File: rtl/parallel_cpu_mult_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | parallel_cpu_mult_pipe                                             |
// | Pipelined signed/unsigned multiplier with valid/ready handshake.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module parallel_cpu_mult_pipe
   import parallel_cpu_mult_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned PP_W        = 16,
   parameter int unsigned PIPE_STAGES = 2
) (
   input logic                     clk,
   input logic                     reset_n,
   parallel_cpu_mult_pipe_if.slave bus
);

   localparam int unsigned c_num_slices = num_slices(DATA_W, PP_W);
   localparam int unsigned c_num_pp     = num_pp(DATA_W, PP_W);
   localparam int unsigned c_pp2_w      = 2 * PP_W;
   localparam int unsigned c_prod_w     = 2 * DATA_W;

   logic                      w_accept;
   logic                      w_load_s1;
   logic                      w_s1_down;
   logic                      w_load_out;

   logic                      r_s1_valid;
   mult_op_t                  r_s1_op;
   logic [DATA_W-1:0]         r_s1_a;
   logic [DATA_W-1:0]         r_s1_b;
   logic                      r_s1_a_neg;
   logic                      r_s1_b_neg;

   logic [c_num_pp*c_pp2_w-1:0] w_pp_flat;
   logic [c_prod_w-1:0]       w_prod;

   logic                      w_fin_valid;
   mult_op_t                  w_fin_op;
   logic [c_prod_w-1:0]       w_fin_prod;
   logic [DATA_W-1:0]         w_fin_a;
   logic [DATA_W-1:0]         w_fin_b;
   logic                      w_fin_a_neg;
   logic                      w_fin_b_neg;
   logic [DATA_W-1:0]         w_fin_h;
   logic [DATA_W-1:0]         w_corr;
   logic [DATA_W-1:0]         w_result;

   logic                      r_out_valid;
   logic [DATA_W-1:0]         r_out_result;

   // Ready ripples back combinationally, so empty stages fill during a stall.
   assign w_load_out = ~r_out_valid | bus.out_ready;
   assign w_load_s1  = ~r_s1_valid | w_s1_down;
   assign w_accept   = bus.in_valid & w_load_s1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= MUL;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_a_neg <= 1'b0;
         r_s1_b_neg <= 1'b0;
      end else begin
         if (w_load_s1) begin
            r_s1_valid <= bus.in_valid;
         end
         if (w_accept) begin
            r_s1_op    <= bus.op;
            r_s1_a     <= bus.src1;
            r_s1_b     <= bus.src2;
            r_s1_a_neg <= bus.src1[DATA_W-1];
            r_s1_b_neg <= bus.src2[DATA_W-1];
         end
      end
   end

   for (genvar gi = 0; gi < c_num_slices; gi++) begin : g_pp_row
      for (genvar gj = 0; gj < c_num_slices; gj++) begin : g_pp_col
         localparam int unsigned c_k = gi * c_num_slices + gj;

         parallel_cpu_mult_pp_slice #(
            .PP_W (PP_W)
         ) u_slice (
            .clk     (clk),
            .reset_n (reset_n),
            .i_en    (w_accept),
            .i_a     (bus.src1[gi*PP_W +: PP_W]),
            .i_b     (bus.src2[gj*PP_W +: PP_W]),
            .o_prod  (w_pp_flat[c_k*c_pp2_w +: c_pp2_w])
         );
      end
   end

   // Slice (i,j) carries weight 2^((i+j)*PP_W).
   always_comb begin
      w_prod = '0;
      for (int i = 0; i < c_num_slices; i++) begin
         for (int j = 0; j < c_num_slices; j++) begin
            w_prod = w_prod
                   + (c_prod_w'(w_pp_flat[(i*c_num_slices+j)*c_pp2_w +: c_pp2_w]) << ((i + j) * PP_W));
         end
      end
   end

   if (PIPE_STAGES == 3) begin : g_mid_stage
      logic                r_valid;
      mult_op_t            r_op;
      logic [c_prod_w-1:0] r_prod;
      logic [DATA_W-1:0]   r_a;
      logic [DATA_W-1:0]   r_b;
      logic                r_a_neg;
      logic                r_b_neg;
      logic                w_load;

      assign w_load = ~r_valid | w_load_out;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_valid <= 1'b0;
            r_op    <= MUL;
            r_prod  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_a_neg <= 1'b0;
            r_b_neg <= 1'b0;
         end else if (w_load) begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_op    <= r_s1_op;
               r_prod  <= w_prod;
               r_a     <= r_s1_a;
               r_b     <= r_s1_b;
               r_a_neg <= r_s1_a_neg;
               r_b_neg <= r_s1_b_neg;
            end
         end
      end

      assign w_s1_down   = w_load;
      assign w_fin_valid = r_valid;
      assign w_fin_op    = r_op;
      assign w_fin_prod  = r_prod;
      assign w_fin_a     = r_a;
      assign w_fin_b     = r_b;
      assign w_fin_a_neg = r_a_neg;
      assign w_fin_b_neg = r_b_neg;
   end else begin : g_direct
      assign w_s1_down   = w_load_out;
      assign w_fin_valid = r_s1_valid;
      assign w_fin_op    = r_s1_op;
      assign w_fin_prod  = w_prod;
      assign w_fin_a     = r_s1_a;
      assign w_fin_b     = r_s1_b;
      assign w_fin_a_neg = r_s1_a_neg;
      assign w_fin_b_neg = r_s1_b_neg;
   end

   assign w_fin_h  = w_fin_prod[c_prod_w-1:DATA_W];
   assign w_corr   = DATA_W'(sign_correct(MAX_DATA_W'(w_fin_h), MAX_DATA_W'(w_fin_a),
                                          MAX_DATA_W'(w_fin_b), w_fin_a_neg, w_fin_b_neg,
                                          w_fin_op));
   assign w_result = (w_fin_op == MUL) ? w_fin_prod[DATA_W-1:0] : w_corr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
      end else if (w_load_out) begin
         r_out_valid <= w_fin_valid;
         if (w_fin_valid) begin
            r_out_result <= w_result;
         end
      end
   end

   assign bus.in_ready  = w_load_s1;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_out_valid ? r_out_result : '0;

endmodule
`default_nettype wire

// File: tb/tb_parallel_cpu_mult_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_parallel_cpu_mult_pipe                                          |
// | Directed and random checks of the 32-bit and 64-bit multipliers.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_parallel_cpu_mult_pipe;
   import parallel_cpu_mult_pkg::*;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   logic [63:0] q32[$];
   logic [63:0] q64[$];
   int          held;
   int          drained;
   int          acc32;
   int          acc64;
   int          cyc;
   logic [63:0] pend_exp;

   parallel_cpu_mult_pipe_if #(.DATA_W(32)) b32 ();
   parallel_cpu_mult_pipe_if #(.DATA_W(64)) b64 ();

   parallel_cpu_mult_pipe #(.DATA_W(32), .PP_W(16), .PIPE_STAGES(2)) dut32 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b32)
   );

   parallel_cpu_mult_pipe #(.DATA_W(64), .PP_W(16), .PIPE_STAGES(3)) dut64 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b64)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_word(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%b exp=%b", tag, got, exp);
      end
   endtask

   // Independent reference: sign/zero extend to 128 bits and multiply.
   function automatic logic [63:0] ref_mul(input int w, input logic [1:0] op,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [127:0] mask;
      logic [127:0] ax;
      logic [127:0] bx;
      logic [127:0] p;
      mask = (128'd1 << w) - 128'd1;
      ax   = 128'(a) & mask;
      bx   = 128'(b) & mask;
      if ((op == 2'd1 || op == 2'd2) && a[w-1]) ax = ax | ~mask;
      if (op == 2'd1 && b[w-1]) bx = bx | ~mask;
      p = ax * bx;
      if (op == 2'd0) return 64'(p & mask);
      return 64'((p >> w) & mask);
   endfunction

   // Single op through an empty 2-stage pipe with out_ready held high.
   task automatic do_op32(input string tag, input mult_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
      b32.op       = op;
      b32.src1     = a;
      b32.src2     = b;
      b32.in_valid = 1'b1;
      #1;
      chk_bit({tag, "_ready"}, b32.in_ready, 1'b1);
      tick();
      b32.in_valid = 1'b0;
      chk_bit({tag, "_lat1"}, b32.out_valid, 1'b0);
      tick();
      chk_bit({tag, "_valid"}, b32.out_valid, 1'b1);
      chk_word({tag, "_data"}, 64'(b32.result), 64'(exp));
      tick();
   endtask

   initial begin
      // Reset with garbage on the inputs
      b32.in_valid  = 1'b1;
      b32.op        = mult_op_t'(2'($urandom_range(0, 3)));
      b32.src1      = $urandom;
      b32.src2      = $urandom;
      b32.out_ready = 1'($urandom_range(0, 1));
      b64.in_valid  = 1'b1;
      b64.op        = MULXSS;
      b64.src1      = {$urandom, $urandom};
      b64.src2      = {$urandom, $urandom};
      b64.out_ready = 1'b0;
      repeat (3) tick();
      chk_bit("rst_hold_valid", b32.out_valid, 1'b0);
      b32.in_valid  = 1'b0;
      b32.out_ready = 1'b1;
      b64.in_valid  = 1'b0;
      b64.out_ready = 1'b1;
      reset_n       = 1'b1;
      #1;
      chk_bit("rst_out_valid", b32.out_valid, 1'b0);
      chk_word("rst_result", 64'(b32.result), 64'h0);
      chk_bit("rst_in_ready", b32.in_ready, 1'b1);
      chk_bit("rst64_in_ready", b64.in_ready, 1'b1);
      tick();

      // Mode checks with hand-computed results
      do_op32("mul_ff",    MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
      do_op32("mulxuu_ff", MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      do_op32("mulxss_ff", MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      do_op32("mulxsu_ff", MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op32("mulxss_80", MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      do_op32("mulxuu_80", MULXUU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      do_op32("mul_80",    MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
      do_op32("mulxsu_80", MULXSU, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF);
      do_op32("mulxss_mix", MULXSS, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF);

      // 64-bit, 3-stage: -1 * 3 (signed x unsigned) -> high word all ones
      b64.op       = MULXSU;
      b64.src1     = 64'hFFFF_FFFF_FFFF_FFFF;
      b64.src2     = 64'h3;
      b64.in_valid = 1'b1;
      tick();
      b64.in_valid = 1'b0;
      chk_bit("w64_lat1", b64.out_valid, 1'b0);
      tick();
      chk_bit("w64_lat2", b64.out_valid, 1'b0);
      tick();
      chk_bit("w64_valid", b64.out_valid, 1'b1);
      chk_word("w64_data", b64.result, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();

      // Back-to-back: 8 ops, results on 8 consecutive cycles
      for (int c = 0; c < 12; c++) begin
         chk_bit("b2b_valid", b32.out_valid, 1'(c >= 2 && c <= 9));
         if (b32.out_valid) begin
            if (q32.size() == 0) chk_bit("b2b_extra", b32.out_valid, 1'b0);
            else chk_word("b2b_data", 64'(b32.result), q32.pop_front());
         end
         if (c < 8) begin
            b32.op       = mult_op_t'(2'(c % 4));
            b32.src1     = 32'h9E37_79B9 * 32'(c + 1);
            b32.src2     = 32'hF00D_0001 ^ (32'h1111_1111 * 32'(c));
            b32.in_valid = 1'b1;
            #1;
            chk_bit("b2b_in_ready", b32.in_ready, 1'b1);
            q32.push_back(ref_mul(32, b32.op, 64'(b32.src1), 64'(b32.src2)));
         end else begin
            b32.in_valid = 1'b0;
         end
         tick();
      end

      // Backpressure: fill until in_ready drops
      q32.delete();
      b32.out_ready = 1'b0;
      held = 0;
      for (int c = 0; c < 8; c++) begin
         b32.op       = mult_op_t'(2'((c + 1) % 4));
         b32.src1     = 32'h8000_0001 + 32'(c);
         b32.src2     = 32'h7FFF_FFF3 - 32'(c * 7);
         b32.in_valid = 1'b1;
         #1;
         if (!b32.in_ready) break;
         q32.push_back(ref_mul(32, b32.op, 64'(b32.src1), 64'(b32.src2)));
         held++;
         tick();
      end
      chk_word("bp_held", 64'(held), 64'd2);
      for (int c = 0; c < 3; c++) begin
         chk_bit("bp_stall_valid", b32.out_valid, 1'b1);
         chk_bit("bp_stall_ready", b32.in_ready, 1'b0);
         chk_word("bp_stall_data", 64'(b32.result), q32[0]);
         tick();
      end
      pend_exp = ref_mul(32, b32.op, 64'(b32.src1), 64'(b32.src2));
      b32.out_ready = 1'b1;
      #1;
      chk_bit("bp_release_ready", b32.in_ready, 1'b1);
      chk_word("bp_release_data", 64'(b32.result), q32.pop_front());
      q32.push_back(pend_exp);
      tick();
      b32.in_valid = 1'b0;
      drained = 0;
      for (int c = 0; c < 8; c++) begin
         if (b32.out_valid) begin
            if (q32.size() == 0) chk_bit("bp_extra", b32.out_valid, 1'b0);
            else chk_word("bp_drain_data", 64'(b32.result), q32.pop_front());
            drained++;
         end
         tick();
      end
      chk_word("bp_drained", 64'(drained), 64'd2);

      // Asynchronous reset with two ops in flight
      b32.out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         b32.op       = MULXUU;
         b32.src1     = 32'hDEAD_BEEF + 32'(c);
         b32.src2     = 32'h1234_5678;
         b32.in_valid = 1'b1;
         tick();
      end
      b32.in_valid = 1'b0;
      chk_bit("amr_full", b32.out_valid, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_bit("amr_valid_drop", b32.out_valid, 1'b0);
      chk_word("amr_result_zero", 64'(b32.result), 64'h0);
      tick();
      b32.out_ready = 1'b1;
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         chk_bit("amr_no_stale", b32.out_valid, 1'b0);
         tick();
      end

      // Random regression on both widths with random backpressure
      q32.delete();
      q64.delete();
      acc32 = 0;
      acc64 = 0;
      cyc   = 0;
      while ((acc32 < 10000 || acc64 < 10000) && cyc < 60000) begin
         b32.in_valid  = (acc32 < 10000) && ($urandom_range(0, 3) != 0);
         b32.op        = mult_op_t'(2'($urandom_range(0, 3)));
         b32.src1      = $urandom;
         b32.src2      = $urandom;
         b32.out_ready = ($urandom_range(0, 3) != 0);
         b64.in_valid  = (acc64 < 10000) && ($urandom_range(0, 3) != 0);
         b64.op        = mult_op_t'(2'($urandom_range(0, 3)));
         b64.src1      = {$urandom, $urandom};
         b64.src2      = {$urandom, $urandom};
         b64.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) chk_bit("rnd32_extra", b32.out_valid, 1'b0);
            else chk_word("rnd32", 64'(b32.result), q32.pop_front());
         end
         if (b64.out_valid && b64.out_ready) begin
            if (q64.size() == 0) chk_bit("rnd64_extra", b64.out_valid, 1'b0);
            else chk_word("rnd64", b64.result, q64.pop_front());
         end
         if (b32.in_valid && b32.in_ready) begin
            q32.push_back(ref_mul(32, b32.op, 64'(b32.src1), 64'(b32.src2)));
            acc32++;
         end
         if (b64.in_valid && b64.in_ready) begin
            q64.push_back(ref_mul(64, b64.op, b64.src1, b64.src2));
            acc64++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      b32.in_valid  = 1'b0;
      b32.out_ready = 1'b1;
      b64.in_valid  = 1'b0;
      b64.out_ready = 1'b1;
      #1;
      for (int c = 0; c < 8; c++) begin
         if (b32.out_valid) begin
            if (q32.size() == 0) chk_bit("rnd32_extra", b32.out_valid, 1'b0);
            else chk_word("rnd32_drain", 64'(b32.result), q32.pop_front());
         end
         if (b64.out_valid) begin
            if (q64.size() == 0) chk_bit("rnd64_extra", b64.out_valid, 1'b0);
            else chk_word("rnd64_drain", b64.result, q64.pop_front());
         end
         tick();
      end
      chk_word("rnd32_accepted", 64'(acc32), 64'd10000);
      chk_word("rnd64_accepted", 64'(acc64), 64'd10000);
      chk_word("rnd32_left", 64'(q32.size()), 64'd0);
      chk_word("rnd64_left", 64'(q64.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
